axiline_vec_loader: RTL and testbench
=====================================

Name: axiline_vec_loader

Overview:
- Producer-side front end for the Axiline SGD datapath.
- Accepts a narrow element stream of (x, w) pairs, one pair per beat, under valid/ready.
- Packs each frame into the wide lane vectors data_out_x / data_out_w that drive the accelerator's data_in_x / data_in_w.
- Presents the packed vector under a valid/ready handshake; enforces frame length and flags malformed frames.

Parameters:
- bitwidth, 8, width of one element (one lane)
- size, 18, lanes per vector (elements per frame)
- cntBitwidth, 5, element counter width; must satisfy 2^cntBitwidth > size

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  loader can accept a beat
- in_x  input  bitwidth  feature element
- in_w  input  bitwidth  weight element
- in_last  input  1  marks final beat of a frame
- out_valid  output  1  packed vector available
- out_ready  input  1  downstream accepts vector
- data_out_x  output  bitwidth*size  packed features; lane i at bits [bitwidth*i+bitwidth-1 : bitwidth*i]
- data_out_w  output  bitwidth*size  packed weights; same lane mapping
- err_short  output  1  one-cycle pulse: frame ended before size beats
- err_long  output  1  one-cycle pulse: frame exceeded size beats

Behaviour:
- Reset (rst==0 at clk edge):
  - state=FILL, cnt=0.
  - data_out_x, data_out_w, out_valid, err_short, err_long all cleared to 0.
  - in_ready is gated 0 combinationally while rst==0.
- Beat accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
- in_ready = 1 in FILL and DROP, 0 in FULL.
- out_valid = 1 only in FULL; it is registered (state-derived).
- FILL state, on accept:
  - in_x/in_w are written to lane cnt.
  - If in_last and cnt==size-1: go to FULL; normal frame.
  - If in_last and cnt<size-1: go to FULL; lanes cnt+1..size-1 keep their zeros; err_short=1 next cycle.
  - If !in_last and cnt==size-1: go to DROP; err_long=1 next cycle; all lanes complete.
  - Otherwise: cnt<=cnt+1.
  - No accept: no change.
- DROP state:
  - Beats are accepted and discarded; lanes are not written.
  - Accept with in_last: go to FULL.
- FULL state:
  - Vector held stable; out_valid=1.
  - On output handshake: all lanes cleared to 0, cnt<=0, state<=FILL. out_valid is 0 and in_ready is 1 in the following cycle.
  - out_valid never drops without a handshake. out_ready while out_valid==0 is ignored.
- Latency:
  - out_valid asserts the cycle after the accepted in_last beat.
  - Minimum frame period is size+1 cycles: one bubble per vector.
- Single-beat frame (in_last on first beat): lane0 loaded, err_short pulses, go to FULL.
- err_short and err_long are never asserted together. Each is high exactly one cycle, otherwise 0.
- Reset mid-frame or in FULL/DROP: partial data discarded; state as after reset.
- The next frame has no residue because lanes are cleared on the output handshake and on reset.

Optional Feature:
- Macro: AXL_LOADER_VCNT_EN.
- Defined:
  - Adds output vec_count [15:0].
  - Reset to 0; increments by 1 on each output handshake.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: no vec_count port and no counter logic. All other behaviour is identical.

Test Plan:
- Normal frame: 18 back-to-back beats, x=i+1, w=8'h40+i, in_last on beat 18, out_ready=1 → out_valid high one cycle after beat 18. Lane0 x=8'h01/w=8'h40; lane17 x=8'h12/w=8'h51. No error pulses; in_ready=1 again the next cycle.
- Backpressure: after a full frame, hold out_ready=0 for 10 cycles → out_valid=1 and in_ready=0 throughout, vector bit-stable. Raise out_ready → one cycle later out_valid=0, in_ready=1, outputs all zero.
- Short frame: 5 beats x=8'hA0..8'hA4, in_last on beat 5 → err_short pulses exactly 1 cycle; lanes 0-4 hold the data, lanes 5-17 are 0; out_valid asserts.
- Long frame: 20 beats, in_last on beat 20 → err_long pulses once, the cycle after beat 18. Beats 19-20 accepted but dropped; lanes hold beats 1-18; out_valid the cycle after beat 20.
- Reset mid-frame:
  - Stimulus: 7 beats accepted, rst=0 for 1 cycle.
  - Response: out_valid=0 and outputs all zero.
  - Then a normal 18-beat frame → correct lanes, no residue, no errors.
- Gapped input: in_valid toggled 1/0 over a normal frame → identical packed vector; out_valid the cycle after the in_last accept. With AXL_LOADER_VCNT_EN, vec_count increments by exactly 1 per handshake.

Source files
------------

// File: rtl/axiline_vec_loader.sv
// Packs a frame of (x, w) element beats into wide lane vectors for the Axiline SGD datapath.
// Latency: vector valid the cycle after the in_last beat; backpressure holds the vector and stalls input.
// Optional AXL_LOADER_VCNT_EN adds a saturating count of delivered vectors (vec_count).
module axiline_vec_loader #(
    parameter int bitwidth    = 8,
    parameter int size        = 18,
    parameter int cntBitwidth = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [bitwidth-1:0]      in_x,
    input  logic [bitwidth-1:0]      in_w,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bitwidth*size-1:0] data_out_x,
    output logic [bitwidth*size-1:0] data_out_w,
    output logic                     err_short,
`ifdef AXL_LOADER_VCNT_EN
    output logic                     err_long,
    output logic [15:0]              vec_count
`else
    output logic                     err_long
`endif
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FULL = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [cntBitwidth-1:0] LAST_LANE = cntBitwidth'(size - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [cntBitwidth-1:0]    r_cnt;
    logic [bitwidth*size-1:0]  r_data_x;
    logic [bitwidth*size-1:0]  r_data_w;
    logic                      r_err_short;
    logic                      r_err_long;

    logic w_accept;
    logic w_out_hs;
    logic w_cnt_last;

    assign w_accept   = in_valid & in_ready;
    assign w_out_hs   = out_valid & out_ready;
    assign w_cnt_last = (r_cnt == LAST_LANE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_accept && in_last) begin
                    w_state_nxt = S_FULL;
                end else if (w_accept && w_cnt_last) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (w_accept && in_last) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_out_hs) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // in_ready is masked by reset so no beat is taken while the block is being cleared.
    always_comb begin
        in_ready  = rst & (r_state != S_FULL);
        out_valid = (r_state == S_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_data_x    <= '0;
            r_data_w    <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            if (w_out_hs) begin
                r_cnt    <= '0;
                r_data_x <= '0;
                r_data_w <= '0;
            end else if (w_accept && (r_state == S_FILL)) begin
                for (int i = 0; i < size; i++) begin
                    if (r_cnt == cntBitwidth'(i)) begin
                        r_data_x[i*bitwidth +: bitwidth] <= in_x;
                        r_data_w[i*bitwidth +: bitwidth] <= in_w;
                    end
                end
                if (!in_last && !w_cnt_last) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_err_short <= in_last & ~w_cnt_last;
                r_err_long  <= ~in_last & w_cnt_last;
            end
        end
    end

    assign data_out_x = r_data_x;
    assign data_out_w = r_data_w;
    assign err_short  = r_err_short;
    assign err_long   = r_err_long;

`ifdef AXL_LOADER_VCNT_EN
    logic [15:0] r_vec_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vec_count <= '0;
        end else if (w_out_hs && (r_vec_count != 16'hFFFF)) begin
            r_vec_count <= r_vec_count + 16'd1;
        end
    end

    assign vec_count = r_vec_count;
`endif

endmodule

// File: tb/tb_axiline_vec_loader.sv
// Self-checking bench for axiline_vec_loader: expected vectors are queued as frames are driven.
module tb_axiline_vec_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_x = '0;
    logic [7:0]   in_w = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [143:0] data_out_x;
    logic [143:0] data_out_w;
    logic         err_short;
    logic         err_long;
`ifdef AXL_LOADER_VCNT_EN
    logic [15:0]  vec_count;
`endif

    axiline_vec_loader #(.bitwidth(8), .size(18), .cntBitwidth(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_w       (in_w),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out_x (data_out_x),
        .data_out_w (data_out_w),
        .err_short  (err_short),
`ifdef AXL_LOADER_VCNT_EN
        .err_long   (err_long),
        .vec_count  (vec_count)
`else
        .err_long   (err_long)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [143:0] x;
        logic [143:0] w;
    } vec_t;

    vec_t sb[$];
    vec_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_count = 0;
    int   n_short, n_long, long_beat, early;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [143:0] exp_vec(input int n, input logic [7:0] base);
        logic [143:0] v;
        v = '0;
        for (int i = 0; i < 18; i++) begin
            if (i < n) v[i*8 +: 8] = base + 8'(i);
        end
        return v;
    endfunction

    // Drives n beats; records error pulses and any premature out_valid while driving.
    task automatic drive_frame(input int n, input logic [7:0] xb, input logic [7:0] wb,
                               input bit gap, input bit send_last);
        n_short = 0; n_long = 0; long_beat = -1; early = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_x     = xb + 8'(i);
            in_w     = wb + 8'(i);
            in_last  = send_last && (i == n - 1);
            tick();
            if (err_short === 1'b1) n_short++;
            if (err_long === 1'b1) begin n_long++; long_beat = i; end
            if (i < n - 1 && out_valid !== 1'b0) early++;
            if (gap && i < n - 1) begin
                in_valid = 1'b0;
                in_x     = 8'hEE;
                tick();
                if (err_short === 1'b1) n_short++;
                if (err_long === 1'b1) n_long++;
                if (out_valid !== 1'b0) early++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        n_checks++;
        if ({out_valid, in_ready, err_short, err_long} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {out_valid, in_ready, err_short, err_long});
        end
        n_checks++;
        if ({data_out_x, data_out_w} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h want 0", data_out_x, data_out_w);
        end
`ifdef AXL_LOADER_VCNT_EN
        n_checks++;
        if (vec_count !== 16'd0) begin n_fail++; $display("FAIL reset_vcnt: got %0d want 0", vec_count); end
`endif
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy: got %b want 1", in_ready); end
    endtask

    task automatic test_normal();
        out_ready = 1'b1;
        sb.push_back('{x: exp_vec(18, 8'h01), w: exp_vec(18, 8'h40)});
        drive_frame(18, 8'h01, 8'h40, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || early != 0) begin
            n_fail++; $display("FAIL normal_valid: got vld=%b rdy=%b early=%0d want 1 0 0", out_valid, in_ready, early);
        end
        e = sb.pop_front();
        n_checks++;
        if (data_out_x !== e.x || data_out_w !== e.w) begin
            n_fail++; $display("FAIL normal_data: got %h/%h want %h/%h", data_out_x, data_out_w, e.x, e.w);
        end
        n_checks++;
        if (data_out_x[7:0] !== 8'h01 || data_out_w[143:136] !== 8'h51) begin
            n_fail++; $display("FAIL normal_lanes: got x0=%h w17=%h want 01 51", data_out_x[7:0], data_out_w[143:136]);
        end
        n_checks++;
        if (n_short != 0 || n_long != 0) begin
            n_fail++; $display("FAIL normal_err: got short=%0d long=%0d want 0 0", n_short, n_long);
        end
        tick(); hs_count++;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL normal_after_hs: got vld,rdy=%b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        sb.push_back('{x: exp_vec(18, 8'h10), w: exp_vec(18, 8'h80)});
        drive_frame(18, 8'h10, 8'h80, 1'b0, 1'b1);
        e = sb.pop_front();
        in_valid = 1'b1; in_x = 8'hFF; in_w = 8'hFF; in_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if ({out_valid, in_ready} !== 2'b10 || data_out_x !== e.x || data_out_w !== e.w) begin
                n_fail++; $display("FAIL bp_hold_%0d: got vld,rdy=%b x=%h want 10 x=%h", c, {out_valid, in_ready}, data_out_x, e.x);
            end
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        tick(); hs_count++;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01 || {data_out_x, data_out_w} !== '0) begin
            n_fail++; $display("FAIL bp_release: got vld,rdy=%b x=%h w=%h want 01 zeros", {out_valid, in_ready}, data_out_x, data_out_w);
        end
    endtask

    task automatic test_short();
        sb.push_back('{x: exp_vec(5, 8'hA0), w: exp_vec(5, 8'h30)});
        drive_frame(5, 8'hA0, 8'h30, 1'b0, 1'b1);
        n_checks++;
        if (err_short !== 1'b1 || err_long !== 1'b0 || n_short != 1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL short_pulse: got short=%b long=%b cnt=%0d vld=%b want 1 0 1 1", err_short, err_long, n_short, out_valid);
        end
        e = sb.pop_front();
        n_checks++;
        if (data_out_x !== e.x || data_out_w !== e.w) begin
            n_fail++; $display("FAIL short_data: got %h/%h want %h/%h", data_out_x, data_out_w, e.x, e.w);
        end
        tick(); hs_count++;
        n_checks++;
        if (err_short !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL short_one_cycle: got short=%b vld=%b want 0 0", err_short, out_valid);
        end
    endtask

    task automatic test_long();
        sb.push_back('{x: exp_vec(18, 8'h60), w: exp_vec(18, 8'hC0)});
        drive_frame(20, 8'h60, 8'hC0, 1'b0, 1'b1);
        n_checks++;
        if (n_long != 1 || long_beat != 17 || n_short != 0) begin
            n_fail++; $display("FAIL long_err: got long=%0d at beat %0d short=%0d want 1 at 17, 0", n_long, long_beat, n_short);
        end
        n_checks++;
        if (out_valid !== 1'b1 || early != 0 || err_long !== 1'b0) begin
            n_fail++; $display("FAIL long_valid: got vld=%b early=%0d err_long=%b want 1 0 0", out_valid, early, err_long);
        end
        e = sb.pop_front();
        n_checks++;
        if (data_out_x !== e.x || data_out_w !== e.w) begin
            n_fail++; $display("FAIL long_data: got %h/%h want %h/%h", data_out_x, data_out_w, e.x, e.w);
        end
        tick(); hs_count++;
    endtask

    task automatic test_reset_mid();
        drive_frame(7, 8'h55, 8'h66, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        hs_count = 0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {data_out_x, data_out_w} !== '0) begin
            n_fail++; $display("FAIL mid_reset: got vld=%b rdy=%b x=%h want 0 1 zeros", out_valid, in_ready, data_out_x);
        end
        sb.push_back('{x: exp_vec(18, 8'h01), w: exp_vec(18, 8'h40)});
        drive_frame(18, 8'h01, 8'h40, 1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || data_out_x !== e.x || data_out_w !== e.w || n_short != 0 || n_long != 0) begin
            n_fail++; $display("FAIL mid_next_frame: got vld=%b x=%h w=%h want 1 %h %h", out_valid, data_out_x, data_out_w, e.x, e.w);
        end
        tick(); hs_count++;
`ifdef AXL_LOADER_VCNT_EN
        n_checks++;
        if (vec_count !== 16'(hs_count)) begin n_fail++; $display("FAIL mid_vcnt: got %0d want %0d", vec_count, hs_count); end
`endif
    endtask

    task automatic test_gapped();
        sb.push_back('{x: exp_vec(18, 8'h21), w: exp_vec(18, 8'h91)});
        drive_frame(18, 8'h21, 8'h91, 1'b1, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || early != 0 || data_out_x !== e.x || data_out_w !== e.w) begin
            n_fail++; $display("FAIL gap_frame: got vld=%b early=%0d x=%h want 1 0 %h", out_valid, early, data_out_x, e.x);
        end
        n_checks++;
        if (n_short != 0 || n_long != 0) begin
            n_fail++; $display("FAIL gap_err: got short=%0d long=%0d want 0 0", n_short, n_long);
        end
        tick(); hs_count++;
`ifdef AXL_LOADER_VCNT_EN
        n_checks++;
        if (vec_count !== 16'(hs_count)) begin n_fail++; $display("FAIL gap_vcnt: got %0d want %0d", vec_count, hs_count); end
`endif
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL gap_after_hs: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_short();
        test_long();
        test_reset_mid();
        test_gapped();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
